// File: rtl/filtro_secuenciador_pkg.sv
// Shared constants for the biquad sequencer: data width, operand-select codes,
// coefficient values (read by the operand multiplexer) and the FSM encoding.
`ifndef FILTRO_ANCHO
`define FILTRO_ANCHO 24
`endif

package filtro_secuenciador_pkg;

  localparam int ANCHO = `FILTRO_ANCHO;
  localparam int FRAC  = 16;

  // bar1: coefficient select
  localparam logic [2:0] SEL1_A1   = 3'd0;
  localparam logic [2:0] SEL1_A2   = 3'd1;
  localparam logic [2:0] SEL1_B0   = 3'd2;
  localparam logic [2:0] SEL1_B1   = 3'd3;
  localparam logic [2:0] SEL1_B2   = 3'd4;
  localparam logic [2:0] SEL1_CERO = 3'd5;

  // bar2: state-term select
  localparam logic [1:0] SEL2_FK   = 2'd0;
  localparam logic [1:0] SEL2_FK1  = 2'd1;
  localparam logic [1:0] SEL2_FK2  = 2'd2;
  localparam logic [1:0] SEL2_CERO = 2'd3;

  // bar3: addend select
  localparam logic [1:0] SEL3_UK   = 2'd0;
  localparam logic [1:0] SEL3_ACUM = 2'd1;
  localparam logic [1:0] SEL3_CERO = 2'd2;

  // Q(F) coefficients; a1/a2 already carry the feedback sign
  localparam int COEF_A1 = 32112;
  localparam int COEF_A2 = -15760;
  localparam int COEF_B0 = 3;
  localparam int COEF_B1 = 6;
  localparam int COEF_B2 = 3;

  typedef enum logic [2:0] {
    EST_IDLE,
    EST_S0,
    EST_S1,
    EST_S2,
    EST_S3,
    EST_S4,
    EST_DONE
  } estado_t;

  typedef struct packed {
    logic [2:0] bar1;
    logic [1:0] bar2;
    logic [1:0] bar3;
  } selects_t;

  function automatic selects_t selects_de(estado_t e);
    selects_t s;
    s.bar1 = SEL1_CERO;
    s.bar2 = SEL2_CERO;
    s.bar3 = SEL3_CERO;
    case (e)
      EST_S0: begin s.bar1 = SEL1_A1; s.bar2 = SEL2_FK1; s.bar3 = SEL3_UK;   end
      EST_S1: begin s.bar1 = SEL1_A2; s.bar2 = SEL2_FK2; s.bar3 = SEL3_ACUM; end
      EST_S2: begin s.bar1 = SEL1_B0; s.bar2 = SEL2_FK;  s.bar3 = SEL3_CERO; end
      EST_S3: begin s.bar1 = SEL1_B1; s.bar2 = SEL2_FK1; s.bar3 = SEL3_ACUM; end
      EST_S4: begin s.bar1 = SEL1_B2; s.bar2 = SEL2_FK2; s.bar3 = SEL3_ACUM; end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic es_paso(estado_t e);
    return (e inside {EST_S0, EST_S1, EST_S2, EST_S3, EST_S4});
  endfunction

endpackage

// File: rtl/filtro_secuenciador_mac_saturado.sv
// Combinational multiply-add with floor scaling by 2^F and saturation to W bits.
module mac_saturado #(
  parameter int W = 24,
  parameter int F = 16
) (
  input  logic [W-1:0] op1_i,
  input  logic [W-1:0] op2_i,
  input  logic [W-1:0] op3_i,
  output logic [W-1:0] r_o,
  output logic         sat_o
);

  // Wide enough that neither the shift nor the add can wrap before saturation.
  localparam int SW = 2*W - F + 1;
  localparam logic signed [SW-1:0] MAX_S = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W-1:0] producto;
  logic signed [SW-1:0]  suma;

  always_comb begin
    producto = $signed(op1_i) * $signed(op2_i);
    suma     = SW'(producto >>> F) + SW'($signed(op3_i));
    r_o      = suma[W-1:0];
    sat_o    = 1'b0;
    if (suma > MAX_S) begin
      r_o   = {1'b0, {(W-1){1'b1}}};
      sat_o = 1'b1;
    end else if (suma < MIN_S) begin
      r_o   = {1'b1, {(W-1){1'b0}}};
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/filtro_secuenciador.sv
// Biquad sequencer: steps five multiply-adds per sample through the external
// operand multiplexer and keeps the filter state, accumulator and output.
module filtro_secuenciador
  import filtro_secuenciador_pkg::*;
#(
  parameter int W = ANCHO,
  parameter int F = FRAC
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] Uk_in,
  input  logic [W-1:0] operando1,
  input  logic [W-1:0] operando2,
  input  logic [W-1:0] operando3,
  output logic [2:0]   bar1,
  output logic [1:0]   bar2,
  output logic [1:0]   bar3,
  output logic [W-1:0] fk,
  output logic [W-1:0] fk1,
  output logic [W-1:0] fk2,
  output logic [W-1:0] acum,
  output logic [W-1:0] Uk,
  output logic [W-1:0] y,
  output logic         done,
  output logic         busy,
  output logic         sat
);

  estado_t        state_q, state_d;
  selects_t       sel_q;
  logic           done_q, busy_q;
  logic [W-1:0]   uk_q, uk_d;
  logic [W-1:0]   acum_q, acum_d;
  logic [W-1:0]   fk_q, fk_d;
  logic [W-1:0]   fk1_q, fk1_d;
  logic [W-1:0]   fk2_q, fk2_d;
  logic [W-1:0]   y_q, y_d;
  logic           sat_q, sat_d;
  logic [W-1:0]   r;
  logic           r_sat;

  mac_saturado #(.W(W), .F(F)) u_mac (
    .op1_i (operando1),
    .op2_i (operando2),
    .op3_i (operando3),
    .r_o   (r),
    .sat_o (r_sat)
  );

  // Selects, busy and done are registered from the next state, so they are
  // glitch-free Moore outputs aligned with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EST_IDLE;
      sel_q   <= selects_de(EST_IDLE);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= selects_de(state_d);
      busy_q  <= (state_d != EST_IDLE);
      done_q  <= (state_d == EST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    uk_d    = uk_q;
    acum_d  = acum_q;
    fk_d    = fk_q;
    fk1_d   = fk1_q;
    fk2_d   = fk2_q;
    y_d     = y_q;
    sat_d   = sat_q;
    case (state_q)
      EST_IDLE: begin
        if (start) begin
          uk_d    = Uk_in;
          sat_d   = 1'b0;
          state_d = EST_S0;
        end
      end
      EST_S0: state_d = EST_S1;
      EST_S1: begin
        fk_d    = r;
        state_d = EST_S2;
      end
      EST_S2: state_d = EST_S3;
      EST_S3: state_d = EST_S4;
      EST_S4: begin
        y_d     = r;
        fk2_d   = fk1_q;
        fk1_d   = fk_q;
        state_d = EST_DONE;
      end
      EST_DONE: state_d = EST_IDLE;
      default:  state_d = EST_IDLE;
    endcase
    if (es_paso(state_q)) begin
      acum_d = r;
      sat_d  = sat_q | r_sat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uk_q   <= '0;
      acum_q <= '0;
      fk_q   <= '0;
      fk1_q  <= '0;
      fk2_q  <= '0;
      y_q    <= '0;
      sat_q  <= 1'b0;
    end else begin
      uk_q   <= uk_d;
      acum_q <= acum_d;
      fk_q   <= fk_d;
      fk1_q  <= fk1_d;
      fk2_q  <= fk2_d;
      y_q    <= y_d;
      sat_q  <= sat_d;
    end
  end

  assign bar1 = sel_q.bar1;
  assign bar2 = sel_q.bar2;
  assign bar3 = sel_q.bar3;
  assign fk   = fk_q;
  assign fk1  = fk1_q;
  assign fk2  = fk2_q;
  assign acum = acum_q;
  assign Uk   = uk_q;
  assign y    = y_q;
  assign done = done_q;
  assign busy = busy_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_filtro_secuenciador.sv
// Bench for filtro_secuenciador: operand multiplexer model, per-sample biquad
// model with a cycle-by-cycle compare process, and directed literal checks.
`timescale 1ns/1ps
module tb_filtro_secuenciador;

  localparam int     W    = 24;
  localparam int     F    = 16;
  localparam longint MAXV = 8388607;
  localparam longint MINV = -8388608;
  localparam longint A1 = 32112, A2 = -15760, B0 = 3, B1 = 6, B2 = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] Uk_in = '0;
  logic [W-1:0] operando1, operando2, operando3;
  logic [2:0]   bar1;
  logic [1:0]   bar2, bar3;
  logic [W-1:0] fk, fk1, fk2, acum, Uk, y;
  logic         done, busy, sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  filtro_secuenciador #(.W(W), .F(F)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .Uk_in(Uk_in),
    .operando1(operando1), .operando2(operando2), .operando3(operando3),
    .bar1(bar1), .bar2(bar2), .bar3(bar3),
    .fk(fk), .fk1(fk1), .fk2(fk2), .acum(acum), .Uk(Uk), .y(y),
    .done(done), .busy(busy), .sat(sat)
  );

  // Operand multiplexer with its coefficient ROM
  always_comb begin
    operando1 = '0;
    operando2 = '0;
    operando3 = '0;
    case (bar1)
      3'd0: operando1 = W'(A1);
      3'd1: operando1 = W'(A2);
      3'd2: operando1 = W'(B0);
      3'd3: operando1 = W'(B1);
      3'd4: operando1 = W'(B2);
      default: operando1 = '0;
    endcase
    case (bar2)
      2'd0: operando2 = fk;
      2'd1: operando2 = fk1;
      2'd2: operando2 = fk2;
      default: operando2 = '0;
    endcase
    case (bar3)
      2'd0: operando3 = Uk;
      2'd1: operando3 = acum;
      default: operando3 = '0;
    endcase
  end

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // One scaled multiply-add with floor and clamping
  function automatic longint paso(input longint c, input longint x, input longint a, inout bit s);
    longint v;
    v = ((c * x) >>> F) + a;
    if (v > MAXV) begin s = 1'b1; v = MAXV; end
    else if (v < MINV) begin s = 1'b1; v = MINV; end
    return v;
  endfunction

  typedef struct { longint w; longint y; bit s; } muestra_t;

  // Direct-form II section: w = u + a1*w1 + a2*w2; y = b0*w + b1*w1 + b2*w2
  function automatic muestra_t biquad(input longint u, input longint h1, input longint h2);
    muestra_t m;
    longint   t;
    bit       s;
    s   = 1'b0;
    t   = paso(A1, h1, u, s);
    m.w = paso(A2, h2, t, s);
    t   = paso(B0, m.w, 0, s);
    t   = paso(B1, h1, t, s);
    m.y = paso(B2, h2, t, s);
    m.s = s;
    return m;
  endfunction

  int       phase = 0;
  longint   m_h1 = 0, m_h2 = 0;
  longint   exp_w = 0, exp_y = 0, exp_fk2 = 0, exp_uk = 0;
  bit       exp_sat = 1'b0;
  muestra_t pred;

  always_comb pred = biquad(sx(Uk_in), m_h1, m_h2);

  // Model timeline: phase k = k-th cycle after an accepted start (6 = done cycle)
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 0;
      m_h1  <= 0;
      m_h2  <= 0;
    end else if (phase == 0) begin
      if (start) begin
        phase   <= 1;
        exp_uk  <= sx(Uk_in);
        exp_w   <= pred.w;
        exp_y   <= pred.y;
        exp_sat <= pred.s;
        exp_fk2 <= m_h1;
        m_h1    <= pred.w;
        m_h2    <= m_h1;
      end
    end else if (phase == 6) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  function automatic logic [6:0] sel_esperado(input int ph);
    case (ph)
      1: return {3'd0, 2'd1, 2'd0};
      2: return {3'd1, 2'd2, 2'd1};
      3: return {3'd2, 2'd0, 2'd2};
      4: return {3'd3, 2'd1, 2'd1};
      5: return {3'd4, 2'd2, 2'd1};
      default: return {3'd5, 2'd3, 2'd2};
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy", longint'(busy), longint'(phase >= 1 && phase <= 6));
      chk("done", longint'(done), longint'(phase == 6));
      chk("selects", longint'({bar1, bar2, bar3}), longint'(sel_esperado(phase)));
      if (phase == 1) chk("sat_cleared_on_start", longint'(sat), 0);
      if (phase == 6) begin
        chk("y", sx(y), exp_y);
        chk("fk", sx(fk), exp_w);
        chk("fk1", sx(fk1), exp_w);
        chk("fk2", sx(fk2), exp_fk2);
        chk("Uk", sx(Uk), exp_uk);
        chk("sat", longint'(sat), longint'(exp_sat));
      end
    end
  end

  task automatic run_sample(input longint u, input int poke_c, input longint poke_u,
                            output longint ry, output longint rfk, output longint rfk1,
                            output longint rfk2, output longint rsat, output int ndone);
    ndone = 0; ry = 0; rfk = 0; rfk1 = 0; rfk2 = 0; rsat = 0;
    @(negedge clk);
    start = 1'b1;
    Uk_in = W'(u);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        ry = sx(y); rfk = sx(fk); rfk1 = sx(fk1); rfk2 = sx(fk2); rsat = longint'(sat);
      end
      start = (c == poke_c);
      if (c == poke_c) Uk_in = W'(poke_u);
    end
    start = 1'b0;
    $display("sample Uk_in=%0d -> y=%0d fk=%0d fk1=%0d fk2=%0d sat=%0d dones=%0d",
             u, ry, rfk, rfk1, rfk2, rsat, ndone);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    longint   ry, rfk, rfk1, rfk2, rsat;
    int       nd;
    muestra_t mm;

    // Pin the model against hand-derived values
    mm = biquad(65536, 0, 0);
    chk("model_imp1_y", mm.y, 3);
    mm = biquad(0, 65536, 0);
    chk("model_imp2_w", mm.w, 32112);
    chk("model_imp2_y", mm.y, 7);
    mm = biquad(0, -65536, 0);
    chk("model_neg2_y", mm.y, -8);

    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_y", sx(y), 0);
    chk("rst_fk", sx(fk), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_selects", longint'({bar1, bar2, bar3}), longint'({3'd5, 2'd3, 2'd2}));
    reset_n = 1'b1;

    // Impulse response
    run_sample(65536, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("imp1_dones", nd, 1);
    chk("imp1_y", ry, 3);
    chk("imp1_fk", rfk, 65536);
    run_sample(0, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("imp2_y", ry, 7);
    chk("imp2_fk", rfk, 32112);
    chk("imp2_fk1", rfk1, 32112);
    chk("imp2_fk2", rfk2, 65536);
    run_sample(0, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("imp3_dones", nd, 1);

    // Asynchronous reset in the middle of a cycle, during S1
    @(negedge clk); start = 1'b1; Uk_in = W'(longint'(100));
    @(negedge clk); start = 1'b0;
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("arst_y", sx(y), 0);
    chk("arst_fk1", sx(fk1), 0);
    chk("arst_fk2", sx(fk2), 0);
    chk("arst_acum", sx(acum), 0);
    chk("arst_Uk", sx(Uk), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_selects", longint'({bar1, bar2, bar3}), longint'({3'd5, 2'd3, 2'd2}));
    $display("async reset mid-cycle: y=%0d busy=%0d", sx(y), busy);
    @(negedge clk); reset_n = 1'b1;

    // Negative input and floor rounding
    run_sample(-65536, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("neg1_y", ry, -3);
    run_sample(0, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("neg2_fk", rfk, -32112);
    chk("neg2_y", ry, -8);

    // Saturation
    reset_pulse();
    run_sample(8388607, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("sat1_sat", rsat, 0);
    run_sample(8388607, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("sat2_fk", rfk, 8388607);
    chk("sat2_sat", rsat, 1);
    run_sample(0, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("sat3_sat", rsat, 0);

    // Starts outside IDLE are ignored (in S2 and in DONE)
    reset_pulse();
    run_sample(65536, 3, -1000, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("ign_s2_dones", nd, 1);
    chk("ign_s2_y", ry, 3);
    chk("ign_s2_fk", rfk, 65536);
    run_sample(0, 6, 12345, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("ign_done_dones", nd, 1);
    chk("ign_done_y", ry, 7);

    // Reset during S3 aborts the sample and clears history
    @(negedge clk); start = 1'b1; Uk_in = W'(longint'(65536));
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (i == 1) reset_n = 1'b1;
    end
    chk("rst_s3_no_done", nd, 0);
    $display("reset in S3: dones=%0d", nd);
    run_sample(65536, 0, 0, ry, rfk, rfk1, rfk2, rsat, nd);
    chk("after_rst_y", ry, 3);
    chk("after_rst_dones", nd, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
